// File: rtl/mux_arb_n_pkg.sv
// mux_pkg: mode encodings and the modulo-N increment shared by
// the round-robin arbiter and its reference model.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int inc_mod(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: N producer valid/ready ports, one consumer
// port, mode/sel controls and the grant index.
interface mux_arb_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   grant;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output mode,
    output sel,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  grant
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  mode,
    input  sel,
    output out_data,
    output out_valid,
    input  out_ready,
    output grant
  );

endinterface

// File: rtl/mux_arb_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from
// last+1 upward modulo N; the pointer register lives outside.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  int w_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = int'(last);
    for (int k = 0; k < N; k++) begin
      w_idx = inc_mod(w_idx, N);
      if (!gnt_valid && req[w_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N:1 mux with direct or round-robin select.
// Optional stall counter port enabled by MUX_ARB_PERF_EN.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_arb_n_if.slave  bus
`ifdef MUX_ARB_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int SEL_W = $clog2(N);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_grant;
  logic [SEL_W-1:0] r_last;

  logic             w_load;
  logic             w_rr;
  logic             w_gnt_valid;
  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_pick_ok;
  logic [SEL_W-1:0] w_pick_idx;
  logic [N-1:0]     w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req       (bus.in_valid),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_load     = !r_out_valid || bus.out_ready;
  assign w_rr       = (bus.mode == MODE_RR);
  assign w_pick_ok  = w_rr ? w_gnt_valid : 1'b1;
  assign w_pick_idx = w_rr ? w_gnt_idx : bus.sel;

  // An out-of-range sel matches no index, so nothing is ready
  always_comb begin
    w_ready = '0;
    w_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick_idx == SEL_W'(i)) begin
        w_data     = bus.in_data[i*WIDTH +: WIDTH];
        w_ready[i] = rst_n && w_load && w_pick_ok;
      end
    end
  end

  assign w_accept = |(w_ready & bus.in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_grant     <= '0;
      r_last      <= SEL_W'(N - 1);
    end else if (w_load) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_data <= w_data;
        r_grant    <= w_pick_idx;
        if (w_rr) r_last <= w_pick_idx;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.grant     = r_grant;

`ifdef MUX_ARB_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !bus.out_ready
                 && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised, registered N:1 datapath multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the fixed 32-bit 2:1 combinational muxes in the multi-cycle CPU datapath.
- Two modes:
  - Direct: an externally driven select chooses the input.
  - Round-robin: the block arbitrates among valid inputs.
- Used where several producers (e.g. register file, memory data register, immediate unit) share one consumer across cycles.

Parameters:
- WIDTH, 32: data width of each input and of the output.
- N, 4: number of inputs, minimum 2.
- SEL_W, $clog2(N): width of sel and grant. Derived; do not override.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-input valid.
- in_ready  output  N  per-input ready; combinational.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_W  input index used in direct mode.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- grant  output  SEL_W  index of the input whose data is held in out_data; registered.

Behaviour:
- Reset: asynchronous on rst_n low; all outputs and state cleared while rst_n is low.
  - out_valid=0, out_data=0, grant=0, in_ready=0.
  - Round-robin pointer last=N-1, so input 0 has first priority.
- Output register:
  - load = !out_valid || out_ready.
  - Exactly one output stage; latency is 1 cycle from input acceptance to out_valid.
  - Full throughput: one transfer per cycle while out_ready=1.
- Direct mode (mode=0):
  - in_ready[sel] = load; all other in_ready = 0.
  - On load && in_valid[sel]: out_data <= input sel, grant <= sel, out_valid <= 1.
  - sel >= N (possible when N is not a power of 2): no input ready, nothing accepted.
- Round-robin mode (mode=1):
  - Search order is last+1, last+2, … modulo N; the first input with in_valid=1 is the winner.
  - in_ready[winner] = load; all other in_ready = 0.
  - On acceptance: out_data, grant and last are all set to the winner.
  - last changes only on an accepted transfer.
- Empty load cycle: load with no accepted input sets out_valid <= 0; out_data and grant hold their values.
- Stall (out_valid && !out_ready): out_data, out_valid and grant hold; all in_ready = 0.
- Consume and refill in the same cycle: out_ready=1 with a valid winner loads new data; out_valid stays 1.
- Mode or sel change: sampled combinationally each cycle and affects only the next acceptance. Data already registered is unaffected; last is preserved across mode switches.
- in_ready never depends on the in_valid of a non-selected input in direct mode. In round-robin mode it depends on in_valid, by construction.
- Reset asserted mid-transfer: the held datum is discarded and no handshake completes in that cycle.

Optional Feature:
- Macro: MUX_ARB_PERF_EN.
- Defined:
  - Extra output port stall_cnt, 32 bits, reset 0.
  - Increments every cycle with out_valid && !out_ready; saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package mux_pkg holds:
  - localparams MODE_DIRECT=1'b0 and MODE_RR=1'b1;
  - a modulo-N increment function shared by the arbiter and the bench.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N-1:0], last[SEL_W-1:0];
  - outputs: gnt_valid, gnt_idx[SEL_W-1:0];
  - purely combinational. The pointer register lives in mux_arb_n.

Test Plan:
- Reset, then direct mode, N=4, WIDTH=32, sel=2, in_valid=4'b0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEAD_BEEF, grant=2.
- Round-robin, all four inputs valid continuously, out_ready=1 -> grant sequence 0,1,2,3,0 on consecutive cycles with matching out_data.
- Round-robin, out_ready held 0 for 3 cycles after the first transfer -> out_data/grant stable, in_ready=0 for 3 cycles; with MUX_ARB_PERF_EN defined, stall_cnt=3.
- Round-robin, last=1, only inputs 0 and 3 valid -> input 3 granted first, then input 0.
- Direct mode, N=3 (SEL_W=2), sel=3 -> in_ready=3'b000, out_valid falls to 0 after the current datum is consumed.
- rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0 immediately, without waiting for a clock edge; after release, round-robin grants input 0 first.
